// File: rtl/cube_frame_buffer.sv
// Double-buffered frame store for the cube driver.
// A loader fills the back bank byte by byte; a swap request at a frame boundary
// makes the completed back bank the front bank. The driver reads the front bank
// combinationally. A frame is only replaced at a swap, so the display never tears.
module cube_frame_buffer #(
    parameter int unsigned FRAME_BYTES = 64,
    parameter int unsigned DATA_W      = 8,
    localparam int unsigned AddrW      = $clog2(FRAME_BYTES)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    // loader side
    input  logic              wr_valid_i,
    input  logic [DATA_W-1:0] wr_data_i,
    output logic              wr_ready_o,
    input  logic              wr_clear_i,
    // frame sequencer side
    input  logic              swap_req_i,
    output logic              swap_ack_o,
    output logic              underrun_o,
    output logic [7:0]        underrun_cnt_o,
    output logic              frame_avail_o,
    output logic              front_valid_o,
    // driver side
    input  logic [AddrW-1:0]  rd_addr_i,
    output logic [DATA_W-1:0] rd_data_o
);

    localparam logic [AddrW-1:0] LastAddr = AddrW'(FRAME_BYTES - 1);

    typedef enum logic [0:0] {
        StFill,
        StFull
    } state_e;

    state_e             state_q, state_d;
    logic [AddrW-1:0]   wr_ptr_q, wr_ptr_d;
    logic               front_sel_q, front_sel_d;
    logic               front_valid_q, front_valid_d;
    logic               swap_ack_q, swap_ack_d;
    logic               underrun_q, underrun_d;
    logic [7:0]         underrun_cnt_q, underrun_cnt_d;

    logic               wr_accept;
    logic               do_swap;

    // Both banks live in one array; the MSB of the index selects the bank.
    logic [DATA_W-1:0]  mem_q [2*FRAME_BYTES];

    // Handshake and swap qualification; wr_clear wins over both writes and swaps.
    always_comb begin
        wr_ready_o = (state_q == StFill) && !wr_clear_i;
        wr_accept  = wr_valid_i && wr_ready_o;
        do_swap    = swap_req_i && (state_q == StFull) && !wr_clear_i;
    end

    // Write FSM, bank select and swap/underrun bookkeeping.
    always_comb begin
        state_d        = state_q;
        wr_ptr_d       = wr_ptr_q;
        front_sel_d    = front_sel_q;
        front_valid_d  = front_valid_q;
        swap_ack_d     = 1'b0;
        underrun_d     = 1'b0;
        underrun_cnt_d = underrun_cnt_q;

        if (swap_req_i && !do_swap) begin
            underrun_d = 1'b1;
            if (underrun_cnt_q != 8'hFF) begin
                underrun_cnt_d = underrun_cnt_q + 8'd1;
            end
        end

        if (wr_clear_i) begin
            state_d  = StFill;
            wr_ptr_d = '0;
        end else if (do_swap) begin
            state_d       = StFill;
            wr_ptr_d      = '0;
            front_sel_d   = !front_sel_q;
            front_valid_d = 1'b1;
            swap_ack_d    = 1'b1;
        end else if (wr_accept) begin
            if (wr_ptr_q == LastAddr) begin
                wr_ptr_d = '0;
                state_d  = StFull;
            end else begin
                wr_ptr_d = wr_ptr_q + AddrW'(1);
            end
        end
    end

    // Control state register with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q        <= StFill;
            wr_ptr_q       <= '0;
            front_sel_q    <= 1'b0;
            front_valid_q  <= 1'b0;
            swap_ack_q     <= 1'b0;
            underrun_q     <= 1'b0;
            underrun_cnt_q <= '0;
        end else begin
            state_q        <= state_d;
            wr_ptr_q       <= wr_ptr_d;
            front_sel_q    <= front_sel_d;
            front_valid_q  <= front_valid_d;
            swap_ack_q     <= swap_ack_d;
            underrun_q     <= underrun_d;
            underrun_cnt_q <= underrun_cnt_d;
        end
    end

    // Back-bank write port; storage is deliberately not reset.
    always_ff @(posedge clk_i) begin
        if (wr_accept && !rst_i) begin
            mem_q[{!front_sel_q, wr_ptr_q}] <= wr_data_i;
        end
    end

    // Front-bank read, blanked until the first frame has been swapped in.
    always_comb begin
        rd_data_o = '0;
        if (front_valid_q) begin
            rd_data_o = mem_q[{front_sel_q, rd_addr_i}];
        end
    end

    // Registered status outputs.
    always_comb begin
        swap_ack_o     = swap_ack_q;
        underrun_o     = underrun_q;
        underrun_cnt_o = underrun_cnt_q;
        frame_avail_o  = (state_q == StFull);
        front_valid_o  = front_valid_q;
    end

endmodule

// File: tb/tb_cube_frame_buffer.sv
// Self-checking bench for cube_frame_buffer: a short table of hand-computed
// vectors, directed frame sequences and a randomized run, all compared against
// a queue-based reference model of the frame store.
module tb_cube_frame_buffer;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_valid;
    logic [7:0] wr_data;
    logic       wr_ready;
    logic       wr_clear;
    logic       swap_req;
    logic       swap_ack;
    logic       underrun;
    logic [7:0] underrun_cnt;
    logic       frame_avail;
    logic       front_valid;
    logic [5:0] rd_addr;
    logic [7:0] rd_data;

    int total = 0;
    int bad   = 0;

    cube_frame_buffer #(
        .FRAME_BYTES(64),
        .DATA_W     (8)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .wr_valid_i    (wr_valid),
        .wr_data_i     (wr_data),
        .wr_ready_o    (wr_ready),
        .wr_clear_i    (wr_clear),
        .swap_req_i    (swap_req),
        .swap_ack_o    (swap_ack),
        .underrun_o    (underrun),
        .underrun_cnt_o(underrun_cnt),
        .frame_avail_o (frame_avail),
        .front_valid_o (front_valid),
        .rd_addr_i     (rd_addr),
        .rd_data_o     (rd_data)
    );

    always #5 clk = ~clk;

    // Reference model: pending frame as a queue, displayed frame as an array.
    logic [7:0] back_q[$];
    logic [7:0] front_m [64];
    bit         fv_m;
    int         cnt_m;
    bit         ack_m;
    bit         und_m;
    bit         check_en;

    function automatic void chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void model_update();
        bit full;
        bit nack;
        bit nund;
        if (rst) begin
            back_q.delete();
            fv_m  = 0;
            cnt_m = 0;
            ack_m = 0;
            und_m = 0;
            return;
        end
        full = (back_q.size() == 64);
        nack = swap_req && full && !wr_clear;
        nund = swap_req && !nack;
        if (wr_clear) begin
            back_q.delete();
        end else if (nack) begin
            for (int i = 0; i < 64; i++) front_m[i] = back_q[i];
            fv_m = 1;
            back_q.delete();
        end else if (wr_valid && back_q.size() < 64) begin
            back_q.push_back(wr_data);
        end
        if (nund && cnt_m < 255) cnt_m++;
        ack_m = nack;
        und_m = nund;
    endfunction

    function automatic void check_model();
        chk("wr_ready", int'(wr_ready), int'(back_q.size() < 64 && !wr_clear));
        chk("frame_avail", int'(frame_avail), int'(back_q.size() == 64));
        chk("swap_ack", int'(swap_ack), int'(ack_m));
        chk("underrun", int'(underrun), int'(und_m));
        chk("underrun_cnt", int'(underrun_cnt), cnt_m);
        chk("front_valid", int'(front_valid), int'(fv_m));
        chk("rd_data", int'(rd_data), fv_m ? int'(front_m[rd_addr]) : 0);
    endfunction

    task automatic apply(input bit r, input bit v, input logic [7:0] d, input bit c,
                         input bit s, input logic [5:0] a);
        @(negedge clk);
        rst      = r;
        wr_valid = v;
        wr_data  = d;
        wr_clear = c;
        swap_req = s;
        rd_addr  = a;
        #1;
    endtask

    task automatic finish_cyc();
        @(posedge clk);
        model_update();
    endtask

    task automatic cyc(input bit r, input bit v, input logic [7:0] d, input bit c,
                       input bit s, input logic [5:0] a);
        apply(r, v, d, c, s, a);
        if (check_en) check_model();
        finish_cyc();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 8'h00, 0, 0, 6'(i));
    endtask

    task automatic load_frame(input bit invert, input int first, input int count);
        for (int k = first; k < first + count; k++) begin
            cyc(0, 1, invert ? 8'(8'hFF - k) : 8'(k), 0, 0, 6'(k));
        end
    endtask

    task automatic pulse_swap();
        cyc(0, 0, 8'h00, 0, 1, 6'd0);
    endtask

    typedef struct {
        bit         v;
        logic [7:0] d;
        bit         c;
        bit         s;
        logic [5:0] a;
        bit         e_ready;
        bit         e_avail;
        bit         e_ack;
        bit         e_und;
        bit         e_fv;
        logic [7:0] e_cnt;
        logic [7:0] e_rd;
    } vec_t;

    vec_t vecs[9];

    initial begin
        // Hand-computed vectors starting from a fresh reset.
        vecs[0] = '{0, 8'h00, 0, 0, 6'd5,  1, 0, 0, 0, 0, 8'd0, 8'h00};
        vecs[1] = '{0, 8'h00, 0, 1, 6'd0,  1, 0, 0, 0, 0, 8'd0, 8'h00};
        vecs[2] = '{0, 8'h00, 0, 0, 6'd63, 1, 0, 0, 1, 0, 8'd1, 8'h00};
        vecs[3] = '{0, 8'h00, 0, 0, 6'd1,  1, 0, 0, 0, 0, 8'd1, 8'h00};
        vecs[4] = '{1, 8'hAA, 1, 0, 6'd2,  0, 0, 0, 0, 0, 8'd1, 8'h00};
        vecs[5] = '{0, 8'h00, 0, 0, 6'd3,  1, 0, 0, 0, 0, 8'd1, 8'h00};
        vecs[6] = '{1, 8'h11, 0, 0, 6'd4,  1, 0, 0, 0, 0, 8'd1, 8'h00};
        vecs[7] = '{0, 8'h00, 1, 1, 6'd5,  0, 0, 0, 0, 0, 8'd1, 8'h00};
        vecs[8] = '{0, 8'h00, 0, 0, 6'd6,  1, 0, 0, 1, 0, 8'd2, 8'h00};

        check_en = 0;
        for (int i = 0; i < 64; i++) front_m[i] = 8'h00;
        fv_m = 0; cnt_m = 0; ack_m = 0; und_m = 0;
        cyc(1, 0, 8'h00, 0, 0, 6'd0);
        cyc(1, 0, 8'h00, 0, 0, 6'd0);
        check_en = 1;

        for (int i = 0; i < 9; i++) begin
            apply(0, vecs[i].v, vecs[i].d, vecs[i].c, vecs[i].s, vecs[i].a);
            chk("tbl_wr_ready", int'(wr_ready), int'(vecs[i].e_ready));
            chk("tbl_frame_avail", int'(frame_avail), int'(vecs[i].e_avail));
            chk("tbl_swap_ack", int'(swap_ack), int'(vecs[i].e_ack));
            chk("tbl_underrun", int'(underrun), int'(vecs[i].e_und));
            chk("tbl_front_valid", int'(front_valid), int'(vecs[i].e_fv));
            chk("tbl_underrun_cnt", int'(underrun_cnt), int'(vecs[i].e_cnt));
            chk("tbl_rd_data", int'(rd_data), int'(vecs[i].e_rd));
            finish_cyc();
        end

        // Fresh reset, blank read sweep.
        cyc(1, 0, 8'h00, 0, 0, 6'd0);
        idle(64);

        // Frame A = k, then swap.
        load_frame(0, 0, 64);
        #1 chk("a_frame_avail", int'(frame_avail), 1);
        chk("a_wr_ready", int'(wr_ready), 0);
        pulse_swap();
        #1 chk("a_swap_ack", int'(swap_ack), 1);
        chk("a_front_valid", int'(front_valid), 1);
        idle(64);

        // Frame B = FF-k while A is shown; hold without swap, then swap.
        load_frame(1, 0, 64);
        idle(64);
        pulse_swap();
        idle(64);

        // Underrun after 10 bytes, then complete the frame.
        load_frame(0, 100, 10);
        pulse_swap();
        #1 chk("u_underrun", int'(underrun), 1);
        chk("u_cnt", int'(underrun_cnt), 1);
        load_frame(0, 110, 54);
        #1 chk("u_frame_avail", int'(frame_avail), 1);

        // Clear together with swap in FULL: no swap, new frame follows.
        cyc(0, 0, 8'h00, 1, 1, 6'd7);
        #1 chk("c_underrun", int'(underrun), 1);
        chk("c_cnt", int'(underrun_cnt), 2);
        chk("c_frame_avail", int'(frame_avail), 0);
        load_frame(0, 50, 64);
        pulse_swap();
        idle(64);

        // Saturate the underrun counter.
        for (int i = 0; i < 300; i++) begin
            pulse_swap();
            cyc(0, 0, 8'h00, 0, 0, 6'(i));
        end
        #1 chk("sat_cnt", int'(underrun_cnt), 255);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 199) == 0), ($urandom_range(0, 9) < 7), 8'($urandom),
                ($urandom_range(0, 39) == 0), ($urandom_range(0, 19) == 0),
                6'($urandom));
        end

        // Reset mid-fill returns every output to its reset value.
        cyc(0, 0, 8'h00, 1, 0, 6'd0);
        pulse_swap();
        load_frame(0, 0, 64);
        pulse_swap();
        load_frame(0, 0, 20);
        cyc(1, 0, 8'h00, 0, 0, 6'd9);
        #1 chk("r_wr_ready", int'(wr_ready), 1);
        chk("r_swap_ack", int'(swap_ack), 0);
        chk("r_underrun", int'(underrun), 0);
        chk("r_cnt", int'(underrun_cnt), 0);
        chk("r_frame_avail", int'(frame_avail), 0);
        chk("r_front_valid", int'(front_valid), 0);
        chk("r_rd_data", int'(rd_data), 0);
        idle(4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cube_frame_buffer.md
# cube_frame_buffer

Double-buffered 64-byte frame store that sits directly upstream of the per-frame cube driver. An external loader (UART receiver, pattern generator or ROM walker) streams 8-bit layer/latch bytes into a back bank with a valid/ready handshake. The frame sequencer requests a bank swap at each frame boundary. The driver reads the front bank by 6-bit address. Frames are therefore replaced only on frame boundaries, with no tearing.

## Interface
Parameters:
- FRAME_BYTES, 64, bytes per frame (8 layers x 8 latches); address width is clog2 = 6
- DATA_W, 8, byte width (one latch's column data)

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- wr_valid  in  1  loader presents a byte
- wr_data  in  8  byte; stream order is address 0..63 (addr = {layer[2:0], latch[2:0]})
- wr_ready  out  1  back bank can accept a byte
- wr_clear  in  1  discard partially or fully loaded back frame
- swap_req  in  1  single-cycle pulse from the frame sequencer at a frame boundary
- swap_ack  out  1  single-cycle pulse: swap performed
- underrun  out  1  single-cycle pulse: swap_req arrived with no full back frame
- underrun_cnt  out  8  saturating count of underruns
- frame_avail  out  1  back bank holds a complete frame awaiting swap
- front_valid  out  1  a frame has been swapped in since reset
- rd_addr  in  6  read address from the cube driver
- rd_data  out  8  front-bank byte at rd_addr; combinational

## Operation
- Storage: two banks of 64 x 8 bits. `front_sel` (1 bit) selects the front bank; the other bank is the back bank. Memory contents are not reset.
- Write FSM states:
  - FILL: wr_ready = 1. The byte is accepted when wr_valid & wr_ready. It is written to back[wr_ptr], and wr_ptr increments (6 bits). On acceptance with wr_ptr == 63: wr_ptr wraps to 0 and the FSM goes to FULL.
  - FULL: wr_ready = 0, frame_avail = 1. The FSM waits for a swap.
- Swap: swap_req in FULL (and wr_clear low) does the following in one cycle:
  - front_sel toggles
  - swap_ack pulses
  - front_valid sets (sticky until rst)
  - FSM returns to FILL with wr_ptr = 0
- Underrun: swap_req while in FILL, or while wr_clear is high:
  - front bank unchanged
  - underrun pulses
  - underrun_cnt increments, saturating at 255
- wr_clear (any state): wr_ptr goes to 0 and FSM goes to FILL.
  - A byte offered in the same cycle is not accepted (wr_ready forced 0 that cycle).
  - wr_clear has priority over swap_req.
- Read: rd_data = front_valid ? front[rd_addr] : 8'h00. Before the first swap the cube is therefore blank.
- Reads and writes never touch the same bank, so there is no read/write hazard.

## Timing
- Reset values:
  - wr_ready = 1
  - swap_ack = 0, underrun = 0, underrun_cnt = 0
  - frame_avail = 0, front_valid = 0
  - rd_data = 0
  - front_sel = 0, wr_ptr = 0, state FILL
- Reset mid-fill or mid-FULL: pending frame discarded; the front bank's contents remain in memory but are hidden because front_valid = 0.
- Write throughput: 1 byte per cycle. The 64th accepted byte (edge N) makes frame_avail = 1 and wr_ready = 0 from cycle N+1.
- swap_req in the same cycle as the 64th byte is accepted: the FSM is still in FILL, so this is an underrun. The frame swaps at the next swap_req.
- Swap latency: swap_req at edge N gives swap_ack high during cycle N+1, and rd_data reflects the new bank from cycle N+1.
- wr_ready returns to 1 in the cycle after the swap.
- rd_data is combinational from rd_addr and registered front_sel/front_valid (zero-cycle read latency, as the driver requires).
- swap_ack and underrun are mutually exclusive and each lasts exactly 1 cycle per swap_req.
- underrun_cnt at 255 stays 255; there is no wrap.

## Test plan
- Reset, then set rd_addr = 0..63 → rd_data = 00 for all; wr_ready = 1; front_valid = 0; underrun_cnt = 0.
- Stream bytes 0x00..0x3F, then pulse swap_req:
  - frame_avail rises after the 64th byte
  - swap_ack occurs one cycle after swap_req
  - rd_data at rd_addr = k equals k
  - wr_ready returns to 1
- Load frame B = 0xFF-k while frame A is displayed, with no swap_req → rd_data still returns A and wr_ready = 0 after 64 bytes. Then pulse swap_req → rd_data returns B.
- Pulse swap_req after 10 bytes → underrun pulses, underrun_cnt = 1, front unchanged. Continue with 54 more bytes → frame_avail = 1.
- Assert wr_clear in FULL together with swap_req → no swap, underrun_cnt increments, wr_ptr = 0, and the next 64 bytes form the new frame.
- Issue 300 swap_req pulses with no data → underrun_cnt = 255 (saturated). Then assert rst mid-fill → all outputs return to their reset values.
